// File: rtl/if_mem_resp.sv
// if_mem_resp: responder end of the CPU instruction-fetch port.
// Serves fetches from a one-word tagged buffer. On a miss it stalls the core
// and assembles the word little-endian from a byte-wide memory (req/ack).
// Optional background prefetch of the next word: define IF_MEM_PREFETCH_EN.
// MEM_AW must be in 1..32.
module if_mem_resp #(
  parameter int unsigned MEM_AW    = 17,
  parameter logic [31:0] INIT_DATA = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              stallreq_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_i
);

  localparam int unsigned TAG_W = 30;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t           state;
  logic [TAG_W-1:0] buf_tag;
  logic [31:0]      buf_word;
  logic             buf_valid;
  logic [TAG_W-1:0] fetch_tag;
  logic [1:0]       byte_idx;
  logic [23:0]      asm_word;

  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic             miss;
  logic             ack_ok;
  logic             restart;
  logic             unused_addr_bits;

`ifdef IF_MEM_PREFETCH_EN
  logic [TAG_W-1:0] pf_tag;
  logic [31:0]      pf_word;
  logic             pf_valid;
  logic             is_pf;
  logic [TAG_W-1:0] next_tag;
  logic             pf_hit;
  logic             claim_pf;
`endif

  // Byte address of lane idx within word tag, truncated to the memory width
  function automatic logic [MEM_AW-1:0] byte_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [1:0] idx);
    return MEM_AW'({tag, idx});
  endfunction

  // Hit/miss decode against the demand buffer; outputs quiet during reset
  always_comb begin
    addr_tag   = rom_addr_i[31:2];
    hit        = rom_ce_i & buf_valid & (buf_tag == addr_tag);
    miss       = rom_ce_i & ~hit;
    rom_data_o = (hit & ~rst) ? buf_word : INIT_DATA;
    stallreq_o = miss & ~rst;
    ack_ok     = mem_ack_i & mem_req_o & (state == FETCH);
    restart    = miss & (addr_tag != fetch_tag);
  end

  assign unused_addr_bits = ^rom_addr_i[1:0];

`ifdef IF_MEM_PREFETCH_EN
  // Prefetch bookkeeping: next sequential word and demand takeover of a prefetch
  always_comb begin
    next_tag = buf_tag + 30'd1;
    pf_hit   = pf_valid & (pf_tag == addr_tag);
    claim_pf = is_pf & miss & (addr_tag == fetch_tag);
  end
`endif

  // Fetch FSM, buffer(s) and registered memory request
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      buf_tag    <= '0;
      buf_word   <= '0;
      fetch_tag  <= '0;
      byte_idx   <= 2'd0;
      asm_word   <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
`ifdef IF_MEM_PREFETCH_EN
      pf_valid   <= 1'b0;
      pf_tag     <= '0;
      pf_word    <= '0;
      is_pf      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef IF_MEM_PREFETCH_EN
          if (miss && pf_hit) begin
            // Promote the prefetched word; hit visible next cycle
            buf_word <= pf_word;
            buf_tag  <= pf_tag;
            pf_valid <= 1'b0;
          end else if (miss) begin
            fetch_tag  <= addr_tag;
            byte_idx   <= 2'd0;
            is_pf      <= 1'b0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= byte_addr(addr_tag, 2'd0);
            state      <= FETCH;
          end else if (hit && (!pf_valid || pf_tag != next_tag)) begin
            fetch_tag  <= next_tag;
            byte_idx   <= 2'd0;
            is_pf      <= 1'b1;
            mem_req_o  <= 1'b1;
            mem_addr_o <= byte_addr(next_tag, 2'd0);
            state      <= FETCH;
          end
`else
          if (miss) begin
            fetch_tag  <= addr_tag;
            byte_idx   <= 2'd0;
            mem_req_o  <= 1'b1;
            mem_addr_o <= byte_addr(addr_tag, 2'd0);
            state      <= FETCH;
          end
`endif
        end

        FETCH: begin
`ifdef IF_MEM_PREFETCH_EN
          if (claim_pf) begin
            is_pf <= 1'b0;
          end
`endif
          if (ack_ok) begin
            if (restart) begin
              // Outstanding byte done; drop partial word and chase the new address
              fetch_tag  <= addr_tag;
              byte_idx   <= 2'd0;
              mem_addr_o <= byte_addr(addr_tag, 2'd0);
`ifdef IF_MEM_PREFETCH_EN
              is_pf      <= 1'b0;
`endif
            end else if (byte_idx != 2'd3) begin
              case (byte_idx)
                2'd0:    asm_word[7:0]   <= mem_data_i;
                2'd1:    asm_word[15:8]  <= mem_data_i;
                default: asm_word[23:16] <= mem_data_i;
              endcase
              byte_idx   <= byte_idx + 2'd1;
              mem_addr_o <= byte_addr(fetch_tag, byte_idx + 2'd1);
            end else begin
`ifdef IF_MEM_PREFETCH_EN
              if (is_pf && !claim_pf) begin
                pf_word  <= {mem_data_i, asm_word};
                pf_tag   <= fetch_tag;
                pf_valid <= 1'b1;
              end else begin
                buf_word  <= {mem_data_i, asm_word};
                buf_tag   <= fetch_tag;
                buf_valid <= 1'b1;
              end
              is_pf     <= 1'b0;
`else
              buf_word  <= {mem_data_i, asm_word};
              buf_tag   <= fetch_tag;
              buf_valid <= 1'b1;
`endif
              mem_req_o <= 1'b0;
              state     <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_mem_resp.sv
// Directed bench for if_mem_resp with a byte-memory responder of
// programmable ack latency.
module tb_if_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce_i;
  logic [31:0] rom_addr_i;
  logic [31:0] rom_data_o;
  logic        stallreq_o;
  logic        mem_req_o;
  logic [16:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [7:0]  mem_data_i = 8'h00;

  always #5 clk = ~clk;

  if_mem_resp #(.MEM_AW(17), .INIT_DATA(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_ce_i   (rom_ce_i),
    .rom_addr_i (rom_addr_i),
    .rom_data_o (rom_data_o),
    .stallreq_o (stallreq_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i)
  );

  logic [7:0]  mem [0:255];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  // responder state
  logic        resp_en = 1'b0;
  logic        force_ack = 1'b0;
  int          lat = 0;
  int          wait_cnt = 0;
  logic [16:0] hold_addr = '0;
  int          addr_moves = 0;
  int          last_ack_cyc = 0;
  logic [16:0] ack_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-memory responder: acks after lat idle cycles, logs each acked address
  always @(negedge clk) begin
    if (resp_en && mem_req_o && !rst) begin
      if (wait_cnt > 0 && mem_addr_o != hold_addr) addr_moves++;
      if (wait_cnt == 0) hold_addr = mem_addr_o;
      if (wait_cnt == lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem[mem_addr_o[7:0]];
        ack_log.push_back(mem_addr_o);
        last_ack_cyc = cyc;
        wait_cnt = 0;
      end else begin
        mem_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack_i  = force_ack;
      mem_data_i = 8'hFF;
      wait_cnt   = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until stallreq_o drops; n = cycles taken
  task automatic wait_drop(output int n);
    n = 0;
    while (stallreq_o && n < 200) begin
      tick();
      n++;
    end
    if (stallreq_o) chk("stall_timeout", {31'b0, stallreq_o}, 32'd0);
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a]     = w[7:0];
    mem[a + 1] = w[15:8];
    mem[a + 2] = w[23:16];
    mem[a + 3] = w[31:24];
  endtask

  logic [16:0] exp_sw [6];
  int          n;
  int          guard;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put_word(32'h00, 32'h0010_0513);
    put_word(32'h04, 32'h0002_A283);
    put_word(32'h08, 32'hCAFE_F00D);
    put_word(32'h10, 32'h1234_5678);
    put_word(32'h40, 32'hDEAD_BEEF);
    exp_sw[0] = 17'h08; exp_sw[1] = 17'h09; exp_sw[2] = 17'h40;
    exp_sw[3] = 17'h41; exp_sw[4] = 17'h42; exp_sw[5] = 17'h43;

    rst = 1'b1; rom_ce_i = 1'b1; rom_addr_i = 32'h0; resp_en = 1'b1; lat = 0;

    // reset held two cycles
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_stall", {31'b0, stallreq_o}, 32'd0);
      chk("rst_req",   {31'b0, mem_req_o},  32'd0);
      chk("rst_data",  rom_data_o,          32'h0);
    end
    rst = 1'b0;
    #1;
    chk("cold_c0_stall", {31'b0, stallreq_o}, 32'd1);

    // cold miss, ack every cycle
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("cold_req",   {31'b0, mem_req_o},  32'd1);
      chk("cold_addr",  32'(mem_addr_o),     32'(i - 1));
      chk("cold_stall", {31'b0, stallreq_o}, 32'd1);
    end
    tick();
    chk("cold_c5_stall", {31'b0, stallreq_o}, 32'd0);
    chk("cold_c5_data",  rom_data_o,          32'h0010_0513);
    chk("cold_c5_req",   {31'b0, mem_req_o},  32'd0);

    // repeated hits
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rep_req",   {31'b0, mem_req_o},  32'd0);
      chk("rep_stall", {31'b0, stallreq_o}, 32'd0);
    end
    chk("rep_data", rom_data_o, 32'h0010_0513);

    // next word 0x4
    ack_log.delete();
    rom_addr_i = 32'h4;
    #1;
    chk("w4_stall", {31'b0, stallreq_o}, 32'd1);
    wait_drop(n);
    chk("w4_cycles", 32'(n), 32'd5);
    chk("w4_data",   rom_data_o, 32'h0002_A283);
    chk("w4_nacks",  32'(ack_log.size()), 32'd4);
    if (ack_log.size() > 0) chk("w4_first_addr", 32'(ack_log[0]), 32'h4);

    // three-cycle ack latency
    lat = 3;
    ack_log.delete();
    rom_addr_i = 32'h10;
    #1;
    wait_drop(n);
    chk("lat_cycles",   32'(n),   32'd17);
    chk("lat_drop_cyc", 32'(cyc), 32'(last_ack_cyc + 1));
    chk("lat_moves",    32'(addr_moves), 32'd0);
    chk("lat_nacks",    32'(ack_log.size()), 32'd4);
    chk("lat_data",     rom_data_o, 32'h1234_5678);

    // address switch 0x8 -> 0x40 while byte 1 outstanding
    ack_log.delete();
    rom_addr_i = 32'h8;
    repeat (6) tick();
    chk("sw_byte1_addr", 32'(mem_addr_o), 32'h9);
    rom_addr_i = 32'h40;
    wait_drop(n);
    chk("sw_nacks", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < ack_log.size()) chk("sw_ack_addr", 32'(ack_log[i]), 32'(exp_sw[i]));
    chk("sw_data",  rom_data_o, 32'hDEAD_BEEF);
    chk("sw_moves", 32'(addr_moves), 32'd0);

    // 0x8 partial must not be served
    rom_addr_i = 32'h8;
    #1;
    chk("p8_stall", {31'b0, stallreq_o}, 32'd1);
    chk("p8_data",  rom_data_o, 32'h0);
    tick();
    rom_ce_i = 1'b0;
    #1;
    chk("ce0_stall", {31'b0, stallreq_o}, 32'd0);
    chk("ce0_data",  rom_data_o, 32'h0);
    guard = 0;
    while (mem_req_o && guard < 100) begin
      tick();
      guard++;
    end
    chk("ce0_fetch_done", {31'b0, mem_req_o}, 32'd0);
    rom_ce_i = 1'b1;
    #1;
    chk("ce0_fill_stall", {31'b0, stallreq_o}, 32'd0);
    chk("ce0_fill_data",  rom_data_o, 32'hCAFE_F00D);

    // stray ack with no request
    resp_en = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    tick();
    chk("stray_req",   {31'b0, mem_req_o},  32'd0);
    chk("stray_stall", {31'b0, stallreq_o}, 32'd0);
    chk("stray_data",  rom_data_o, 32'hCAFE_F00D);
    resp_en = 1'b1;

    // reset mid-fetch
    rom_addr_i = 32'h20;
    tick();
    tick();
    chk("rm_pending", {31'b0, mem_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rm_stall", {31'b0, stallreq_o}, 32'd0);
    chk("rm_data",  rom_data_o, 32'h0);
    tick();
    chk("rm_req",  {31'b0, mem_req_o}, 32'd0);
    chk("rm_addr", 32'(mem_addr_o), 32'h0);
    rst = 1'b0;
    rom_ce_i = 1'b0;
    repeat (5) tick();
    chk("rm_idle_req", {31'b0, mem_req_o}, 32'd0);
    rom_ce_i = 1'b1;
    rom_addr_i = 32'h8;
    #1;
    chk("rm_buf_cleared", {31'b0, stallreq_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/if_mem_resp.md
Name: if_mem_resp

Overview:
- Responder end of the CPU instruction-fetch interface.
- Accepts the core's chip-enable and word address, and returns a 32-bit instruction.
- On a miss it raises a stall request to ctrl and assembles the word from a byte-wide external instruction memory using a req/ack handshake.
- A one-word tagged buffer serves repeated fetches of the same address without stalling. The block sits between the CPU top's ROM port and off-core program memory.

Parameters:
- MEM_AW, 17, external memory byte-address width. Must be ≤32.
- INIT_DATA, 32'h0000_0000, value driven on rom_data_o when rom_ce_i=0 or on a miss.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- rom_ce_i  in  1  fetch enable from pc_reg
- rom_addr_i  in  32  fetch byte address; bits [1:0] ignored (word-aligned)
- rom_data_o  out  32  instruction word, valid when rom_ce_i=1 and stallreq_o=0
- stallreq_o  out  1  fetch stall request to ctrl
- mem_req_o  out  1  external read request, registered
- mem_addr_o  out  MEM_AW  external byte address, registered
- mem_ack_i  in  1  one-cycle pulse: mem_data_i valid for the pending request
- mem_data_i  in  8  read byte

Behaviour:
- Reset (rst=1 at clk edge):
  - state←IDLE; buf_valid←0; byte index←0.
  - mem_req_o←0; mem_addr_o←0.
  - While rst=1, stallreq_o=0 and rom_data_o=INIT_DATA.
  - Reset mid-fetch abandons the fetch; any later ack is ignored.
- Hit and miss, combinational:
  - hit = rom_ce_i & buf_valid & (buf_tag == rom_addr_i[31:2]).
  - miss = rom_ce_i & ~hit.
  - rom_data_o = buf_word on hit, otherwise INIT_DATA.
  - stallreq_o = miss.
- FSM states: IDLE, FETCH.
- IDLE:
  - miss → FETCH.
  - Load fetch tag = rom_addr_i[31:2] and byte index = 0.
  - Next cycle: mem_req_o=1, mem_addr_o = {tag, 2'b00} truncated to MEM_AW.
- FETCH:
  - mem_req_o is held high and mem_addr_o is held stable until mem_ack_i=1.
  - On ack, mem_data_i is stored into byte lane [index]. Byte order is little-endian: byte 0 → bits [7:0].
  - If index<3: index+1; mem_addr_o updates to the next byte on the following cycle; mem_req_o stays high.
  - If index=3: buf_word←assembled word; buf_tag←fetch tag; buf_valid←1; mem_req_o←0; → IDLE. The hit is visible the cycle after the final ack.
- Ack may arrive in the same cycle mem_req_o first rises. Ack while mem_req_o=0 is ignored.
- Best case, ack every cycle: miss detected at cycle 0, requests at cycles 1–4, stallreq_o drops at cycle 5.
- Address change mid-fetch, when rom_addr_i[31:2] ≠ fetch tag:
  - The outstanding byte is always completed; the request is never withdrawn before ack.
  - At that ack the partial word is discarded, tag reloads from rom_addr_i, index←0, and the fetch restarts.
  - buf_valid is unaffected.
- rom_ce_i=0 during FETCH: the current fetch completes and fills the buffer; stallreq_o=0.
- Buffer is never invalidated except by reset. Program memory is read-only.
- Address wrap: MEM_AW truncation only; no fault.

Optional Feature:
- Macro: IF_MEM_PREFETCH_EN.
- With the macro defined:
  - Adds a second buffer (pf_word, pf_tag, pf_valid).
  - In IDLE with a hit and pf_tag ≠ buf_tag+1 (or !pf_valid), the block fetches word buf_tag+1 into pf in the background; stallreq_o stays 0.
  - A demand miss whose address equals pf_tag with pf_valid=1 promotes pf into buf in one cycle (stall exactly 1 cycle), and pf_valid←0.
  - A demand miss during a prefetch:
    - If the demand address equals the prefetch tag, the fetch continues as the demand fetch.
    - Otherwise, the outstanding byte completes, the prefetch is aborted, and the demand fetch restarts.
- Without the macro: mem_req_o is asserted only for demand misses. No pf state exists.

Test Plan:
- Reset: hold rst 2 cycles with rom_ce_i=1, addr 0 → stallreq_o=0, mem_req_o=0, rom_data_o=0. After release, cycle 0 shows stallreq_o=1.
- Cold miss, always-ack responder, addr 0x0, bytes 13,05,10,00 → mem_addr_o 0,1,2,3 on cycles 1–4; cycle 5 stallreq_o=0, rom_data_o=32'h00100513.
- Repeat fetch of 0x0 for 10 cycles → no mem_req_o, stallreq_o=0, data stable. Change to 0x4 (0x0002A283) → new 4-byte fetch, data correct.
- Ack latency 3 cycles per byte → mem_req_o and mem_addr_o stable until each ack; stallreq_o drops exactly 1 cycle after the 4th ack.
- Address switch from 0x8 to 0x40 during byte 1 → byte 1 completes; next mem_addr_o=0x40; the buffer ends holding word 0x40's data, and 0x8's partial data is never returned.
- rom_ce_i=0 → rom_data_o=INIT_DATA, stallreq_o=0. Ack pulse with mem_req_o=0 → no state change.
